// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_ctrl
// Purpose  : Write-port controller for the 8x8 register file. Arbitrates the
//            ALU and load writeback sources onto the single write port and
//            sequences a clear-all of every register on request.
// Options  : RR_ARB_EN - round-robin arbitration on simultaneous A/M
//            requests. When undefined, the load (M) source always wins.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                A_VALID,
    input  logic [ADDR_W-1:0]   A_ADDR,
    input  logic [DATA_W-1:0]   A_DATA,
    output logic                A_READY,
    input  logic                M_VALID,
    input  logic [ADDR_W-1:0]   M_ADDR,
    input  logic [DATA_W-1:0]   M_DATA,
    output logic                M_READY,
    input  logic                CLR_REQ,
    output logic                CLR_BUSY,
    output logic                RF_WRITE,
    output logic [ADDR_W-1:0]   RF_INADDRESS,
    output logic [DATA_W-1:0]   RF_IN,
    output logic [NUM_REGS-1:0] PEND
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Counter value of the last register written by the clear sequence.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic                rf_write_q;
    logic [ADDR_W-1:0]   rf_addr_q;
    logic [DATA_W-1:0]   rf_data_q;
    logic                clr_busy_q;

    logic                arb_open;
    logic                grant_a;
    logic                grant_m;

    // Grants are only possible in ARB with no clear pending; a clear request
    // takes the port from both sources.
    assign arb_open = (state_q == ST_ARB) && !CLR_REQ;

`ifdef RR_ARB_EN
    // 0 = prefer M on the next collision, 1 = prefer A.
    logic rr_q;

    // Round-robin grant: pointer only matters when both sources collide.
    always_comb begin
        grant_m = 1'b0;
        grant_a = 1'b0;
        if (arb_open) begin
            if (M_VALID && A_VALID) begin
                grant_m = ~rr_q;
                grant_a = rr_q;
            end else begin
                grant_m = M_VALID;
                grant_a = A_VALID;
            end
        end
    end

    // After any grant the pointer flips its preference to the other source.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rr_q <= 1'b0;
        end else if (grant_m) begin
            rr_q <= 1'b1;
        end else if (grant_a) begin
            rr_q <= 1'b0;
        end
    end
`else
    // Fixed priority: the load is older in program order, so M wins and A
    // retries the following cycle.
    assign grant_m = arb_open && M_VALID;
    assign grant_a = arb_open && A_VALID && !M_VALID;
`endif

    assign A_READY = grant_a;
    assign M_READY = grant_m;
    assign cnt_d   = cnt_q + ADDR_W'(1);

    // Controller FSM; every RF_* output is registered so the file sees a
    // stable write for the whole cycle before its capturing edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_ARB;
            cnt_q      <= '0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    cnt_q <= '0;
                    if (CLR_REQ) begin
                        // First clear write (address 0) is issued right away
                        // so BUSY and the address walk line up cycle for cycle.
                        state_q    <= ST_CLEAR;
                        clr_busy_q <= 1'b1;
                        rf_write_q <= 1'b1;
                        rf_addr_q  <= '0;
                        rf_data_q  <= '0;
                    end else if (grant_m) begin
                        rf_write_q <= 1'b1;
                        rf_addr_q  <= M_ADDR;
                        rf_data_q  <= M_DATA;
                    end else if (grant_a) begin
                        rf_write_q <= 1'b1;
                        rf_addr_q  <= A_ADDR;
                        rf_data_q  <= A_DATA;
                    end else begin
                        rf_write_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        // Last register issued; hand the port back to ARB.
                        state_q    <= ST_ARB;
                        clr_busy_q <= 1'b0;
                        cnt_q      <= '0;
                        rf_write_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_d;
                        rf_write_q <= 1'b1;
                        rf_addr_q  <= cnt_d;
                        rf_data_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    assign RF_WRITE     = rf_write_q;
    assign RF_INADDRESS = rf_addr_q;
    assign RF_IN        = rf_data_q;
    assign CLR_BUSY     = clr_busy_q;

    // Hazard flag for decode: one-hot of the register being written.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_pend
        assign PEND[k] = rf_write_q && (rf_addr_q == ADDR_W'(k));
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_ctrl
// Purpose  : Directed self-checking bench for regfile_write_ctrl, with a
//            behavioural 8x8 register file on the RF_* port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_ctrl;

    logic       CLK;
    logic       RESET;
    logic       A_VALID;
    logic [2:0] A_ADDR;
    logic [7:0] A_DATA;
    logic       A_READY;
    logic       M_VALID;
    logic [2:0] M_ADDR;
    logic [7:0] M_DATA;
    logic       M_READY;
    logic       CLR_REQ;
    logic       CLR_BUSY;
    logic       RF_WRITE;
    logic [2:0] RF_INADDRESS;
    logic [7:0] RF_IN;
    logic [7:0] PEND;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rf_model [8];

    regfile_write_ctrl #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .A_VALID      (A_VALID),
        .A_ADDR       (A_ADDR),
        .A_DATA       (A_DATA),
        .A_READY      (A_READY),
        .M_VALID      (M_VALID),
        .M_ADDR       (M_ADDR),
        .M_DATA       (M_DATA),
        .M_READY      (M_READY),
        .CLR_REQ      (CLR_REQ),
        .CLR_BUSY     (CLR_BUSY),
        .RF_WRITE     (RF_WRITE),
        .RF_INADDRESS (RF_INADDRESS),
        .RF_IN        (RF_IN),
        .PEND         (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: captures the write port on the rising edge.
    always @(posedge CLK) begin
        if (RF_WRITE) rf_model[RF_INADDRESS] <= RF_IN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Continuous M stream: address k, data k+1 (or 8'hFF when ff is set).
    task automatic m_stream(input int n, input bit ff);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            M_VALID = 1'b1;
            M_ADDR  = 3'(k);
            M_DATA  = ff ? 8'hFF : 8'(k + 1);
            @(negedge CLK);
            check("stream_mready", M_READY, 1);
            if (k > 0) begin
                check("stream_wr", RF_WRITE, 1);
                check("stream_addr", RF_INADDRESS, k - 1);
                check("stream_data", RF_IN, ff ? 8'hFF : 8'(k));
            end
        end
        @(posedge CLK); #1;
        M_VALID = 1'b0;
        @(negedge CLK);
        check("stream_last_wr", RF_WRITE, 1);
        check("stream_last_addr", RF_INADDRESS, n - 1);
        check("stream_last_data", RF_IN, ff ? 8'hFF : 8'(n));
        @(negedge CLK);
        check("stream_idle", RF_WRITE, 0);
    endtask

    initial begin
        RESET   = 1'b0;
        A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
        M_VALID = 1'b0; M_ADDR = '0; M_DATA = '0;
        CLR_REQ = 1'b0;

        // ---- reset hold and release ----
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_wr", RF_WRITE, 0);
        check("rst_pend", PEND, 8'h00);
        check("rst_busy", CLR_BUSY, 0);
        check("rst_addr", RF_INADDRESS, 0);
        check("rst_in", RF_IN, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("idle_wr", RF_WRITE, 0);
        check("idle_pend", PEND, 8'h00);
        check("idle_ready", {A_READY, M_READY}, 2'b00);

        // ---- single ALU write ----
        @(posedge CLK); #1;
        A_VALID = 1'b1; A_ADDR = 3'd3; A_DATA = 8'h5A;
        @(negedge CLK);
        check("a_ready", {A_READY, M_READY}, 2'b10);
        @(posedge CLK); #1;
        A_VALID = 1'b0;
        @(negedge CLK);
        check("a_wr", RF_WRITE, 1);
        check("a_addr", RF_INADDRESS, 3);
        check("a_in", RF_IN, 8'h5A);
        check("a_pend", PEND, 8'h08);
        @(negedge CLK);
        check("a_after_wr", RF_WRITE, 0);
        check("a_after_pend", PEND, 8'h00);
        check("a_reg3", rf_model[3], 8'h5A);

        // ---- simultaneous requests to the same register ----
        @(posedge CLK); #1;
        A_VALID = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h22;
        M_VALID = 1'b1; M_ADDR = 3'd2; M_DATA = 8'h11;
`ifdef RR_ARB_EN
        // Sustained collision: grants alternate M, A, M, A.
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rr_grant", {A_READY, M_READY}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) check("rr_data", RF_IN, (k % 2 == 1) ? 8'h11 : 8'h22);
            @(posedge CLK);
        end
        #1;
        A_VALID = 1'b0; M_VALID = 1'b0;
        @(negedge CLK);
        check("rr_last_data", RF_IN, 8'h22);
`else
        @(negedge CLK);
        check("prio_first", {A_READY, M_READY}, 2'b01);
        @(posedge CLK); #1;
        M_VALID = 1'b0;
        @(negedge CLK);
        check("prio_m_data", RF_IN, 8'h11);
        check("prio_second", {A_READY, M_READY}, 2'b10);
        @(posedge CLK); #1;
        A_VALID = 1'b0;
        @(negedge CLK);
        check("prio_a_data", RF_IN, 8'h22);
        check("prio_reg2_mid", rf_model[2], 8'h11);
`endif
        @(negedge CLK);
        check("same_reg2", rf_model[2], 8'h22);

        // ---- continuous M stream, no bubbles ----
        m_stream(4, 1'b0);

        // ---- clear-all with a pending ALU request ----
        m_stream(8, 1'b1);
        @(posedge CLK); #1;
        CLR_REQ = 1'b1;
        A_VALID = 1'b1; A_ADDR = 3'd5; A_DATA = 8'h77;
        @(negedge CLK);
        check("clr_req_ready", {A_READY, M_READY}, 2'b00);
        check("clr_req_busy", CLR_BUSY, 0);
        @(posedge CLK); #1;
        CLR_REQ = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check("clr_busy", CLR_BUSY, 1);
            check("clr_wr", RF_WRITE, 1);
            check("clr_addr", RF_INADDRESS, k);
            check("clr_in", RF_IN, 0);
            check("clr_ready", {A_READY, M_READY}, 2'b00);
            @(posedge CLK);
        end
        @(negedge CLK);
        check("clr_done_busy", CLR_BUSY, 0);
        check("clr_done_aready", A_READY, 1);
        for (int r = 0; r < 8; r++) check("clr_reg_zero", rf_model[r], 0);
        @(posedge CLK); #1;
        A_VALID = 1'b0;
        @(negedge CLK);
        check("clr_a_addr", RF_INADDRESS, 5);
        check("clr_a_in", RF_IN, 8'h77);

        // ---- asynchronous reset aborts a clear at step 4 ----
        m_stream(8, 1'b1);
        @(posedge CLK); #1;
        CLR_REQ = 1'b1;
        @(posedge CLK); #1;
        CLR_REQ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            @(posedge CLK);
        end
        @(negedge CLK);
        check("abort_step", RF_INADDRESS, 4);
        #2;
        RESET = 1'b0;
        #1;
        check("abort_busy", CLR_BUSY, 0);
        check("abort_wr", RF_WRITE, 0);
        check("abort_pend", PEND, 8'h00);
        check("abort_addr", RF_INADDRESS, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        A_VALID = 1'b1; A_ADDR = 3'd1; A_DATA = 8'h33;
        @(negedge CLK);
        check("abort_arb_ready", A_READY, 1);
        check("abort_idle_busy", CLR_BUSY, 0);
        for (int r = 0; r < 4; r++) check("abort_low_regs", rf_model[r], 8'h00);
        for (int r = 4; r < 8; r++) check("abort_high_regs", rf_model[r], 8'hFF);
        @(posedge CLK); #1;
        A_VALID = 1'b0;
        CLR_REQ = 1'b1;
        @(negedge CLK);
        check("abort_a_in", RF_IN, 8'h33);
        @(posedge CLK); #1;
        CLR_REQ = 1'b0;
        @(negedge CLK);
        check("restart_busy", CLR_BUSY, 1);
        check("restart_addr0", RF_INADDRESS, 0);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        check("restart_done", CLR_BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Write-port controller for the 8x8 register file: two writeback sources, the ALU result and the memory load, share the single write port (WRITE/INADDRESS/IN).
- Arbitrates with valid/ready handshakes, registers the granted write one cycle ahead of the file's posedge write, and sequences a full register clear on request.
- Sits between the execute/memory stages and the register file; the controller's RF_* outputs drive the file directly.

Parameters:
- DATA_W, 8, write data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, registers cleared by the clear sequence (= 2**ADDR_W)

Ports:
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  asynchronous, active-low reset
- A_VALID  in  1  ALU writeback request
- A_ADDR  in  ADDR_W  ALU destination register
- A_DATA  in  DATA_W  ALU result
- A_READY  out  1  ALU request accepted this cycle
- M_VALID  in  1  load writeback request
- M_ADDR  in  ADDR_W  load destination register
- M_DATA  in  DATA_W  load data
- M_READY  out  1  load request accepted this cycle
- CLR_REQ  in  1  start clear-all sequence (level, sampled)
- CLR_BUSY  out  1  clear sequence in progress
- RF_WRITE  out  1  to register file WRITE
- RF_INADDRESS  out  ADDR_W  to register file INADDRESS
- RF_IN  out  DATA_W  to register file IN
- PEND  out  NUM_REGS  bit k high = a write to register k is issued on RF_* this cycle

Behaviour:
- Reset (RESET=0, asynchronous): FSM=ARB; RF_WRITE=0, RF_INADDRESS=0, RF_IN=0, CLR_BUSY=0, PEND=0, clear counter=0, rr pointer=0. Async reset applies mid-clear too: sequence aborted, no resume.
- Handshake: transfer when X_VALID && X_READY at a posedge. READY is combinational from FSM state, CLR_REQ and the VALIDs. Requesters hold VALID/ADDR/DATA stable until accepted.
- Latency: a request accepted at edge N appears on RF_* (RF_WRITE=1) during cycle N..N+1. The file writes it at edge N+1. An idle cycle drives RF_WRITE=0 at the next edge.
- FSM state ARB:
  - If CLR_REQ=1: both READY=0; next state CLEAR; CLR_BUSY=1 from the next edge.
  - Else if only one VALID is high: that source gets READY=1.
  - Else if both are high: fixed priority, M wins (M_READY=1, A_READY=0); A stalls and retries next cycle.
  - Accepted ADDR/DATA register into RF_INADDRESS/RF_IN with RF_WRITE=1.
- FSM state CLEAR:
  - A_READY=M_READY=0. Each cycle RF_WRITE=1, RF_IN=0, RF_INADDRESS=counter; counter increments 0..NUM_REGS-1.
  - After the write of address NUM_REGS-1 is issued, next state ARB, CLR_BUSY=0, counter=0. Total NUM_REGS write cycles.
  - CLR_REQ is ignored while in CLEAR. CLR_REQ still high on return to ARB starts another clear.
- Same address from A and M in one cycle: M written first, A on a later cycle. The file ends holding A's data (program order: load older).
- Back-to-back grants allowed: a write every cycle, no bubbles.
- PEND is a one-hot of RF_INADDRESS when RF_WRITE=1, else 0. Decode uses it as a hazard flag.
- Widths are exact; no arithmetic on data. The counter wraps to 0 only via the return to ARB.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration on simultaneous A/M requests.
  - 1-bit pointer, reset to 0 (M preferred); after any grant the pointer prefers the other source.
  - Single requests are granted regardless of the pointer. CLEAR still overrides both.
- Undefined: fixed priority, M over A; no pointer logic.

Test Plan:
- Reset hold, then release with no VALIDs -> RF_WRITE=0, PEND=8'h00, CLR_BUSY=0. Assert RESET=0 mid-cycle -> outputs zero immediately, no clock needed.
- A_VALID=1, A_ADDR=3, A_DATA=8'h5A for one accepted edge -> next cycle RF_WRITE=1, RF_INADDRESS=3, RF_IN=8'h5A, PEND=8'h08; file reg3=8'h5A; following cycle RF_WRITE=0.
- Both VALID, M_ADDR=A_ADDR=2, M_DATA=8'h11, A_DATA=8'h22:
  - Without RR_ARB_EN: M granted first, then A; reg2 ends 8'h22.
  - With RR_ARB_EN: a sustained double request alternates M, A, M, A.
- CLR_REQ pulse with all registers preloaded to 8'hFF -> CLR_BUSY high 8 cycles; RF_INADDRESS walks 0..7 with RF_IN=0; READYs low throughout; all registers read 0 afterwards; a pending A request is granted in the first ARB cycle.
- Async RESET=0 at clear step 4 -> sequence aborted, CLR_BUSY=0, counter=0. After release the FSM is in ARB and registers 4..7 keep their old values.
- Continuous M requests for 4 cycles (addr 0..3, data 8'h01..8'h04) -> four consecutive RF_WRITE cycles, no bubbles, data in order.
